// File: rtl/gamepad_wb.sv
// Wishbone scanner for two serial SNES/NES-style pads on shared latch/clock/select.
// Button word and scan count update atomically at the end of each scan.
module gamepad_wb #(
    parameter int DIV     = 150,
    parameter int NBITS   = 16,
    parameter int POLL_TW = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        gp_sel,
    input  logic [1:0]  gp_data,
    output logic        gp_latch,
    output logic        gp_clk
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_GAP, S_CLK_LO, S_CLK_HI, S_DONE
    } state_t;

    localparam logic [8:0] LAT_END  = 9'(2 * DIV - 1);
    localparam logic [8:0] UNIT_END = 9'(DIV - 1);
    localparam logic [4:0] BITS_N   = 5'(NBITS);
    localparam logic [POLL_TW-1:0] POLL_ONE = {{(POLL_TW-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic               ack_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               auto_en_q, sel_req_q, gp_sel_q;
    logic [15:0]        data0_q, data1_q, sh0_q, sh1_q, count_q;
    logic [4:0]         bits_q;
    logic [8:0]         tmr_q;
    logic [POLL_TW-1:0] poll_q;
    logic [1:0]         sync1_q, sync2_q;
    logic               busy;

    logic acc, wr, trig, tick, start, shift_en, scan_go;
    logic unused_wdata;

    assign acc      = wb_cyc & ~ack_q;
    assign wr       = acc & wb_we;
    assign trig     = wr & (wb_addr == 2'd0) & wb_wdata[31];
    assign tick     = &poll_q;
    assign start    = trig | (auto_en_q & tick);
    assign shift_en = (state_d == S_CLK_LO) & (state_q != S_CLK_LO);
    assign scan_go  = (state_q == S_IDLE) & (state_d == S_LATCH);

    assign unused_wdata = ^wb_wdata[30:2];

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign gp_sel   = gp_sel_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LATCH;
            S_LATCH:  if (tmr_q == LAT_END) state_d = S_GAP;
            S_GAP:    if (tmr_q == UNIT_END) state_d = S_CLK_LO;
            S_CLK_LO: if (tmr_q == UNIT_END) state_d = S_CLK_HI;
            S_CLK_HI: begin
                if (tmr_q == UNIT_END)
                    state_d = (bits_q < BITS_N) ? S_CLK_LO : S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        gp_latch = (state_q == S_LATCH);
        gp_clk   = (state_q != S_CLK_LO);
    end

    always_comb begin
        rdata_d = '0;
        unique case (wb_addr)
            2'd0:    rdata_d = {28'd0, gp_sel_q, busy, sel_req_q, auto_en_q};
            2'd1:    rdata_d = {data1_q, data0_q};
            2'd2:    rdata_d = {16'd0, count_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            auto_en_q <= 1'b0;
            sel_req_q <= 1'b0;
            gp_sel_q  <= 1'b0;
            data0_q   <= '0;
            data1_q   <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            count_q   <= '0;
            bits_q    <= '0;
            tmr_q     <= '0;
            poll_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            ack_q   <= acc;
            rdata_q <= acc ? rdata_d : 32'd0;
            if (wr && wb_addr == 2'd0) begin
                auto_en_q <= wb_wdata[0];
                sel_req_q <= wb_wdata[1];
            end
            poll_q  <= poll_q + POLL_ONE;
            sync1_q <= gp_data;
            sync2_q <= sync1_q;
            tmr_q   <= (state_d != state_q) ? 9'd0 : tmr_q + 9'd1;
            // Select only moves while idle so a scan never sees a bank switch.
            if (state_d == S_IDLE) gp_sel_q <= sel_req_q;
            if (scan_go) begin
                bits_q <= '0;
                sh0_q  <= '0;
                sh1_q  <= '0;
            end
            if (shift_en) begin
                sh0_q[bits_q[3:0]] <= ~sync2_q[0];
                sh1_q[bits_q[3:0]] <= ~sync2_q[1];
                bits_q             <= bits_q + 5'd1;
            end
            if (state_q == S_DONE) begin
                data0_q <= sh0_q;
                data1_q <= sh1_q;
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule
